uart_rx: RTL and testbench

Serial receiver for the SoC `uart_rx` pin. It is the receive-side counterpart of the SoC's UART transmit path. The block recovers 8N1 frames from the asynchronous line, oversampling at a fixed clocks-per-bit rate. It presents each byte on a valid/ready interface to the bus-side UART register block, with framing-error and overrun reporting.

---
 rtl/uart_rx.sv | 144 ++++++++++++++
 tb/tb_uart_rx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM,
// and a single-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] C_BIT_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_ONE     = CW'(1);

   typedef enum logic [2:0] {
      S_WAIT_IDLE = 3'd0,
      S_IDLE      = 3'd1,
      S_START     = 3'd2,
      S_DATA      = 3'd3,
      S_STOP      = 3'd4
   } state_t;

   state_t          r_state;
   logic            r_sync1;
   logic            r_rx_s;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_idx;
   logic [7:0]      r_shift;
   logic [7:0]      r_data;
   logic            r_valid;
   logic            r_ferr;
   logic            r_ovr;
   logic            w_accept;
   logic            w_buf_free;

   assign w_accept   = r_valid & rx_ready;
   assign w_buf_free = ~r_valid | rx_ready;

   // Two-flop synchronizer; resets to the idle line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_rx_s  <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_rx_s  <= r_sync1;
      end
   end

   // Receive FSM, output buffer and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_WAIT_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
         r_data  <= 8'h00;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ferr <= 1'b0;
         r_ovr  <= 1'b0;
         // A byte loaded in the STOP branch below overrides this clear.
         if (w_accept) begin
            r_valid <= 1'b0;
         end
         case (r_state)
            S_WAIT_IDLE: begin
               if (r_rx_s) begin
                  r_state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (!r_rx_s) begin
                  r_cnt   <= '0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (r_cnt == C_HALF_M1) begin
                  if (!r_rx_s) begin
                     r_cnt   <= '0;
                     r_idx   <= 3'd0;
                     r_state <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_DATA: begin
               if (r_cnt == C_BIT_M1) begin
                  r_shift <= {r_rx_s, r_shift[7:1]};
                  r_cnt   <= '0;
                  r_idx   <= r_idx + 3'd1;
                  if (r_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_STOP: begin
               if (r_cnt == C_BIT_M1) begin
                  r_cnt <= '0;
                  if (r_rx_s) begin
                     if (w_buf_free) begin
                        r_data  <= r_shift;
                        r_valid <= 1'b1;
                     end else begin
                        r_ovr <= 1'b1;
                     end
                     r_state <= S_IDLE;
                  end else begin
                     // Line may still be low; wait for it to return high before hunting.
                     r_ferr  <= 1'b1;
                     r_state <= S_WAIT_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: begin
               r_state <= S_WAIT_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; frames are driven
// edge-by-edge so latencies can be checked against hand-computed edge numbers.
module tb_uart_rx;

   localparam int CPB = 16;

   logic       clk;
   logic       rst;
   logic       rx;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: delivered bytes, pulse cycle counts, and hold violations.
   logic [7:0] mq[$];
   int   m_fe   = 0;
   int   m_ov   = 0;
   int   m_both = 0;
   int   m_hold = 0;
   logic m_pv   = 1'b0;
   logic m_pr   = 1'b0;
   logic m_prst = 1'b1;
   logic [7:0] m_pd = 8'h00;

   always @(negedge clk) begin
      if (rx_valid && (!m_pv || m_pr)) mq.push_back(rx_data);
      if (m_pv && !m_pr && !m_prst && (!rx_valid || rx_data != m_pd)) m_hold <= m_hold + 1;
      if (frame_err) m_fe <= m_fe + 1;
      if (overrun) m_ov <= m_ov + 1;
      if (frame_err && overrun) m_both <= m_both + 1;
      m_pv   <= rx_valid;
      m_pr   <= rx_ready;
      m_pd   <= rx_data;
      m_prst <= rst;
   end

   // Line level seen at edge n of a frame whose first start-bit edge is n=0.
   function automatic logic frame_bit(input logic [7:0] d, input logic sb, input int n);
      int b;
      b = n / CPB;
      if (b == 0) return 1'b0;
      else if (b <= 8) return d[b-1];
      else if (b == 9) return sb;
      else return 1'b1;
   endfunction

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one full frame; optionally pulses rx_ready at one edge; reports first error-pulse edge.
   task automatic send_frame(input logic [7:0] d, input logic sb, input int rdy_edge, output int ev_edge);
      ev_edge = -1;
      for (int n = 0; n < 10 * CPB; n++) begin
         rx = frame_bit(d, sb, n);
         if (rdy_edge >= 0) rx_ready = (n == rdy_edge);
         @(posedge clk);
         #1;
         if ((frame_err || overrun) && ev_edge < 0) ev_edge = n;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h exp 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rx_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %0b exp 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %0b exp 0", overrun); end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_single;
      int first = -1;
      int vcyc = 0;
      int errp = 0;
      logic [7:0] d_at = 8'h00;
      rx_ready = 1'b1;
      for (int n = 0; n < 180; n++) begin
         rx = frame_bit(8'h55, 1'b1, n);
         @(posedge clk);
         #1;
         if (rx_valid) begin
            vcyc++;
            if (first < 0) begin first = n; d_at = rx_data; end
         end
         if (frame_err || overrun) errp++;
      end
      checks++; if (first !== 154) begin errors++; $display("FAIL single_latency got %0d exp 154", first); end
      checks++; if (vcyc !== 1) begin errors++; $display("FAIL single_valid_cycles got %0d exp 1", vcyc); end
      checks++; if (d_at !== 8'h55) begin errors++; $display("FAIL single_data got %0h exp 55", d_at); end
      checks++; if (errp !== 0) begin errors++; $display("FAIL single_err_pulses got %0d exp 0", errp); end
   endtask

   task automatic test_glitch;
      int q0 = mq.size();
      int f0 = m_fe;
      int o0 = m_ov;
      int ev;
      rx_ready = 1'b1;
      rx = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      idle(40);
      checks++; if (mq.size() - q0 !== 0) begin errors++; $display("FAIL glitch_no_byte got %0d exp 0", mq.size() - q0); end
      checks++; if (m_fe - f0 + m_ov - o0 !== 0) begin errors++; $display("FAIL glitch_no_err got %0d exp 0", m_fe - f0 + m_ov - o0); end
      send_frame(8'hA3, 1'b1, -1, ev);
      idle(10);
      checks++; if (mq.size() - q0 !== 1) begin errors++; $display("FAIL glitch_next_count got %0d exp 1", mq.size() - q0); end
      else begin
         checks++; if (mq[q0] !== 8'hA3) begin errors++; $display("FAIL glitch_next_data got %0h exp a3", mq[q0]); end
      end
   endtask

   task automatic test_frame_err;
      int q0 = mq.size();
      int f0 = m_fe;
      int ev;
      rx_ready = 1'b1;
      send_frame(8'h3C, 1'b0, -1, ev);
      rx = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      checks++; if (ev !== 154) begin errors++; $display("FAIL ferr_edge got %0d exp 154", ev); end
      checks++; if (m_fe - f0 !== 1) begin errors++; $display("FAIL ferr_pulse_cycles got %0d exp 1", m_fe - f0); end
      checks++; if (mq.size() - q0 !== 0) begin errors++; $display("FAIL ferr_no_byte got %0d exp 0", mq.size() - q0); end
      idle(20);
      send_frame(8'h81, 1'b1, -1, ev);
      idle(10);
      checks++; if (mq.size() - q0 !== 1) begin errors++; $display("FAIL ferr_next_count got %0d exp 1", mq.size() - q0); end
      else begin
         checks++; if (mq[q0] !== 8'h81) begin errors++; $display("FAIL ferr_next_data got %0h exp 81", mq[q0]); end
      end
   endtask

   task automatic test_overrun;
      int q0 = mq.size();
      int o0 = m_ov;
      int h0 = m_hold;
      int ev1;
      int ev2;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, -1, ev1);
      send_frame(8'h22, 1'b1, -1, ev2);
      idle(5);
      checks++; if (ev2 !== 154) begin errors++; $display("FAIL ovr_edge got %0d exp 154", ev2); end
      checks++; if (m_ov - o0 !== 1) begin errors++; $display("FAIL ovr_pulse_cycles got %0d exp 1", m_ov - o0); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %0b exp 1", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data got %0h exp 11", rx_data); end
      checks++; if (m_hold - h0 !== 0) begin errors++; $display("FAIL ovr_hold got %0d exp 0", m_hold - h0); end
      checks++; if (mq.size() - q0 !== 1) begin errors++; $display("FAIL ovr_byte_count got %0d exp 1", mq.size() - q0); end
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_valid got %0b exp 0", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_accept_data got %0h exp 11", rx_data); end
   endtask

   task automatic test_simultaneous;
      int q0 = mq.size();
      int o0 = m_ov;
      int ev;
      rx_ready = 1'b0;
      send_frame(8'h11, 1'b1, -1, ev);
      idle(5);
      send_frame(8'h22, 1'b1, 154, ev);
      idle(3);
      checks++; if (ev !== -1) begin errors++; $display("FAIL simul_no_pulse got %0d exp -1", ev); end
      checks++; if (m_ov - o0 !== 0) begin errors++; $display("FAIL simul_ovr got %0d exp 0", m_ov - o0); end
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %0b exp 1", rx_valid); end
      checks++; if (rx_data !== 8'h22) begin errors++; $display("FAIL simul_data got %0h exp 22", rx_data); end
      checks++; if (mq.size() - q0 !== 2) begin errors++; $display("FAIL simul_byte_count got %0d exp 2", mq.size() - q0); end
      else begin
         checks++; if (mq[q0] !== 8'h11 || mq[q0+1] !== 8'h22) begin errors++; $display("FAIL simul_order got %0h %0h exp 11 22", mq[q0], mq[q0+1]); end
      end
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL simul_accept_valid got %0b exp 0", rx_valid); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] exp_b[3];
      int q0;
      int f0;
      int o0;
      int ev;
      exp_b[0] = 8'h01; exp_b[1] = 8'h80; exp_b[2] = 8'hFF;
      rx_ready = 1'b0;
      send_frame(8'h5A, 1'b1, -1, ev);
      idle(5);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %0b exp 1", rx_valid); end
      q0 = mq.size(); f0 = m_fe; o0 = m_ov;
      // Reset lands 10 cycles into bit 3 (line low) of 0xF0.
      for (int n = 0; n < 10 * CPB; n++) begin
         rx  = frame_bit(8'hF0, 1'b1, n);
         rst = (n == 74);
         @(posedge clk);
         #1;
         if (n == 74) begin
            checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || frame_err !== 1'b0 || overrun !== 1'b0) begin
               errors++; $display("FAIL rstmid_outputs got v%0b d%0h f%0b o%0b exp all 0", rx_valid, rx_data, frame_err, overrun);
            end
         end
      end
      rst = 1'b0;
      idle(40);
      checks++; if (mq.size() - q0 !== 0) begin errors++; $display("FAIL rstmid_no_byte got %0d exp 0", mq.size() - q0); end
      rx_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, -1, ev);
      idle(20);
      checks++; if (m_fe - f0 + m_ov - o0 !== 0) begin errors++; $display("FAIL rstmid_no_err got %0d exp 0", m_fe - f0 + m_ov - o0); end
      checks++; if (mq.size() - q0 !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", mq.size() - q0); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (mq[q0+i] !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got %0h exp %0h", i, mq[q0+i], exp_b[i]); end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      rx_ready = 1'b0;
      test_reset;
      test_single;
      test_glitch;
      test_frame_err;
      test_overrun;
      test_simultaneous;
      test_reset_mid;
      checks++; if (m_both !== 0) begin errors++; $display("FAIL pulses_coincide got %0d exp 0", m_both); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
